// File: rtl/axi_spy_drain_arbiter.sv
// Round-robin drain of the four AXI spy FIFOs (R, AR, AW, W) onto a single tagged
// valid/ready trace stream, with a discard-everything flush mode and a saturating word counter.
module axi_spy_drain_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable_i,
   input  logic                    flush_i,
   input  logic [3:0]              ch_empty_i,
   input  logic [4*DATA_WIDTH-1:0] ch_data_i,
   output logic [3:0]              ch_pop_o,
   output logic                    trace_valid_o,
   input  logic                    trace_ready_i,
   output logic [DATA_WIDTH-1:0]   trace_data_o,
   output logic [1:0]              trace_chan_o,
   output logic                    busy_o,
   output logic                    flush_done_o,
   output logic [CNT_WIDTH-1:0]    word_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [1:0]            r_rr_ptr;
   logic                  r_flush_pending;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic [1:0]            r_chan;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic [1:0]            w_grant;
   logic [1:0]            w_idx;
   logic                  w_found;
   logic                  w_any;
   logic                  w_can_load;
   logic                  w_load;
   logic                  w_enter_flush;
   logic                  w_flush_done;
   logic [3:0]            w_pop;

   assign w_any      = ~&ch_empty_i;
   assign w_can_load = ~r_valid | trace_ready_i;

   // First non-empty channel at or after r_rr_ptr, wrapping modulo 4
   always_comb begin
      w_grant = r_rr_ptr;
      w_idx   = r_rr_ptr;
      w_found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_rr_ptr + 2'(k);
         if (!w_found && !ch_empty_i[w_idx]) begin
            w_grant = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_pop         = 4'b0000;
      w_load        = 1'b0;
      w_enter_flush = 1'b0;
      w_flush_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_flush_pending) begin
               w_state_next  = S_FLUSH;
               w_enter_flush = 1'b1;
            end else if (enable_i) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (enable_i && !r_flush_pending && w_can_load && w_any) begin
               w_load         = 1'b1;
               w_pop[w_grant] = 1'b1;
            end
            // Leave RUN only once the held word has been handed off
            if (r_flush_pending && !r_valid) begin
               w_state_next  = S_FLUSH;
               w_enter_flush = 1'b1;
            end else if (!enable_i && !r_valid) begin
               w_state_next = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (!w_any) begin
               w_flush_done = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_pop[w_grant] = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_rr_ptr        <= 2'd0;
         r_flush_pending <= 1'b0;
         r_valid         <= 1'b0;
         r_data          <= '0;
         r_chan          <= 2'd0;
         r_cnt           <= '0;
      end else begin
         r_state <= w_state_next;
         if (|w_pop) r_rr_ptr <= w_grant + 2'd1;
         if (w_enter_flush) begin
            r_flush_pending <= 1'b0;
         end else if (flush_i && r_state != S_FLUSH) begin
            r_flush_pending <= 1'b1;
         end
         if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= ch_data_i[w_grant*DATA_WIDTH +: DATA_WIDTH];
            r_chan  <= w_grant;
         end else if (trace_ready_i) begin
            r_valid <= 1'b0;
         end
         if (r_valid && trace_ready_i && !(&r_cnt)) r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign ch_pop_o      = w_pop;
   assign trace_valid_o = r_valid;
   assign trace_data_o  = r_data;
   assign trace_chan_o  = r_chan;
   assign flush_done_o  = w_flush_done;
   assign word_cnt_o    = r_cnt;
   assign busy_o        = (r_state == S_FLUSH) | ((r_state == S_RUN) & r_valid);

endmodule

// File: tb/tb_axi_spy_drain_arbiter.sv
// Scoreboard bench for axi_spy_drain_arbiter: behavioural spy FIFOs feed the DUT,
// directed tests push expected trace words, and a negedge monitor pops and compares them.
module tb_axi_spy_drain_arbiter;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          trace_ready_i = 1'b0;
   logic [3:0]    ch_empty_i;
   logic [4*DW-1:0] ch_data_i;
   logic [3:0]    ch_pop_o;
   logic          trace_valid_o;
   logic [DW-1:0] trace_data_o;
   logic [1:0]    trace_chan_o;
   logic          busy_o;
   logic          flush_done_o;
   logic [15:0]   word_cnt_o;
   logic [3:0]    pop4;
   logic          valid4;
   logic [DW-1:0] data4;
   logic [1:0]    chan4;
   logic          busy4;
   logic          done4;
   logic [3:0]    cnt4;

   axi_spy_drain_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .enable_i(enable_i), .flush_i(flush_i),
      .ch_empty_i(ch_empty_i), .ch_data_i(ch_data_i), .ch_pop_o(ch_pop_o),
      .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
      .trace_data_o(trace_data_o), .trace_chan_o(trace_chan_o), .busy_o(busy_o),
      .flush_done_o(flush_done_o), .word_cnt_o(word_cnt_o));

   // Narrow-counter twin on the same inputs, used only for the saturation check
   axi_spy_drain_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .enable_i(enable_i), .flush_i(flush_i),
      .ch_empty_i(ch_empty_i), .ch_data_i(ch_data_i), .ch_pop_o(pop4),
      .trace_valid_o(valid4), .trace_ready_i(trace_ready_i),
      .trace_data_o(data4), .trace_chan_o(chan4), .busy_o(busy4),
      .flush_done_o(done4), .word_cnt_o(cnt4));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    chan;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW-1:0] q2[$];
   logic [DW-1:0] q3[$];
   logic [3:0]    last_pop = 4'b0000;
   int            n_chk = 0;
   int            n_fail = 0;
   int            n_pops = 0;
   int            n_words = 0;
   int            n_done = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic refresh();
      ch_empty_i[0] = (q0.size() == 0);
      ch_empty_i[1] = (q1.size() == 0);
      ch_empty_i[2] = (q2.size() == 0);
      ch_empty_i[3] = (q3.size() == 0);
      ch_data_i[0*DW +: DW] = (q0.size() != 0) ? q0[0] : '0;
      ch_data_i[1*DW +: DW] = (q1.size() != 0) ? q1[0] : '0;
      ch_data_i[2*DW +: DW] = (q2.size() != 0) ? q2[0] : '0;
      ch_data_i[3*DW +: DW] = (q3.size() != 0) ? q3[0] : '0;
   endtask

   task automatic push(input int ch, input logic [DW-1:0] d);
      case (ch)
         0: q0.push_back(d);
         1: q1.push_back(d);
         2: q2.push_back(d);
         default: q3.push_back(d);
      endcase
      refresh();
   endtask

   task automatic expect_w(input int ch, input logic [DW-1:0] d);
      exp_t e;
      e.chan = 2'(ch);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Advance one clock; apply the pops the DUT strobed in the cycle just ended
   task automatic tick();
      @(posedge clk);
      #1;
      if (!reset) begin
         if (last_pop[0]) void'(q0.pop_front());
         if (last_pop[1]) void'(q1.pop_front());
         if (last_pop[2]) void'(q2.pop_front());
         if (last_pop[3]) void'(q3.pop_front());
      end
      refresh();
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
   endtask

   // Monitor: pop-rule checks, hold-rule checks, scoreboard compare on each handshake
   initial begin
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic [1:0]    prev_chan;
      exp_t          e;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_chan  = 2'd0;
      forever begin
         @(negedge clk);
         last_pop = ch_pop_o;
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            n_pops += $countones(ch_pop_o);
            if (ch_pop_o != 4'b0000) begin
               chk("pop_onehot", 64'($onehot(ch_pop_o)), 64'd1);
               chk("pop_on_empty", 64'(ch_pop_o & ch_empty_i), 64'd0);
            end
            if (prev_stall) begin
               chk("hold_valid", 64'(trace_valid_o), 64'd1);
               chk("hold_data", 64'(trace_data_o), 64'(prev_data));
               chk("hold_chan", 64'(trace_chan_o), 64'(prev_chan));
            end
            if (trace_valid_o && trace_ready_i) begin
               n_words++;
               $display("trace word %0d: ch=%0d data=%08h", n_words, trace_chan_o, trace_data_o);
               chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("trace_data", 64'(trace_data_o), 64'(e.data));
                  chk("trace_chan", 64'(trace_chan_o), 64'(e.chan));
               end
            end
            if (flush_done_o) n_done++;
            prev_stall = trace_valid_o & ~trace_ready_i;
            prev_data  = trace_data_o;
            prev_chan  = trace_chan_o;
         end
      end
   end

   initial begin
      int p0;
      int w0;
      int d0;
      refresh();
      do_reset();

      // Reset state
      chk("rst_valid", 64'(trace_valid_o), 64'd0);
      chk("rst_data", 64'(trace_data_o), 64'd0);
      chk("rst_chan", 64'(trace_chan_o), 64'd0);
      chk("rst_pop", 64'(ch_pop_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(flush_done_o), 64'd0);
      chk("rst_cnt", 64'(word_cnt_o), 64'd0);

      // Basic order: R{A0,A1}, W{D0} -> A0/ch0, D0/ch3, A1/ch0
      push(0, 32'hA000_0000);
      push(0, 32'hA000_0001);
      push(3, 32'hD000_0000);
      expect_w(0, 32'hA000_0000);
      expect_w(3, 32'hD000_0000);
      expect_w(0, 32'hA000_0001);
      enable_i = 1'b1;
      trace_ready_i = 1'b1;
      ticks(8);
      chk("basic_cnt", 64'(word_cnt_o), 64'd3);
      chk("basic_left", 64'(exp_q.size()), 64'd0);
      enable_i = 1'b0;
      ticks(2);

      // Fairness: two words in every channel -> 0,1,2,3,0,1,2,3
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin
            push(c, 32'hF000_0000 | (r << 8) | c);
            expect_w(c, 32'hF000_0000 | (r << 8) | c);
         end
      p0 = n_pops;
      w0 = n_words;
      enable_i = 1'b1;
      trace_ready_i = 1'b1;
      ticks(14);
      chk("fair_pops", 64'(n_pops - p0), 64'd8);
      chk("fair_words", 64'(n_words - w0), 64'd8);
      chk("fair_cnt", 64'(word_cnt_o), 64'd8);
      chk("fair_cnt4", 64'(cnt4), 64'd8);
      chk("fair_left", 64'(exp_q.size()), 64'd0);

      // Backpressure: held word stays stable, no pops, then resumes
      do_reset();
      push(1, 32'hB000_0000);
      push(1, 32'hB000_0001);
      expect_w(1, 32'hB000_0000);
      expect_w(1, 32'hB000_0001);
      p0 = n_pops;
      enable_i = 1'b1;
      trace_ready_i = 1'b0;
      ticks(3);
      ticks(5);
      chk("bp_pops", 64'(n_pops - p0), 64'd1);
      chk("bp_valid", 64'(trace_valid_o), 64'd1);
      chk("bp_data", 64'(trace_data_o), 64'hB000_0000);
      chk("bp_chan", 64'(trace_chan_o), 64'd1);
      trace_ready_i = 1'b1;
      ticks(4);
      chk("bp_pops_after", 64'(n_pops - p0), 64'd2);
      chk("bp_cnt", 64'(word_cnt_o), 64'd2);
      chk("bp_left", 64'(exp_q.size()), 64'd0);

      // Flush with a stalled word: only C0 is emitted, rest discarded
      do_reset();
      push(0, 32'hC000_0000);
      push(0, 32'hC000_0001);
      push(2, 32'hE000_0000);
      push(2, 32'hE000_0001);
      expect_w(0, 32'hC000_0000);
      p0 = n_pops;
      enable_i = 1'b1;
      trace_ready_i = 1'b0;
      ticks(3);
      flush_i = 1'b1;
      enable_i = 1'b0;
      tick();
      flush_i = 1'b0;
      ticks(3);
      chk("fl_stall_pops", 64'(n_pops - p0), 64'd1);
      chk("fl_stall_valid", 64'(trace_valid_o), 64'd1);
      chk("fl_stall_busy", 64'(busy_o), 64'd1);
      d0 = n_done;
      trace_ready_i = 1'b1;
      ticks(8);
      chk("fl_pops", 64'(n_pops - p0), 64'd4);
      chk("fl_done_pulses", 64'(n_done - d0), 64'd1);
      chk("fl_empty", 64'(ch_empty_i), 64'hF);
      chk("fl_busy", 64'(busy_o), 64'd0);
      chk("fl_cnt", 64'(word_cnt_o), 64'd1);
      chk("fl_left", 64'(exp_q.size()), 64'd0);

      // Flush with everything already empty completes at once
      d0 = n_done;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      ticks(3);
      chk("fl_empty_done", 64'(n_done - d0), 64'd1);
      chk("fl_empty_busy", 64'(busy_o), 64'd0);

      // Asynchronous reset while a word is held; draining restarts from channel 0
      push(0, 32'h6000_0000);
      push(0, 32'h6000_0001);
      push(0, 32'h6000_0002);
      push(1, 32'h7000_0000);
      enable_i = 1'b1;
      trace_ready_i = 1'b0;
      ticks(3);
      chk("mid_valid_pre", 64'(trace_valid_o), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_valid", 64'(trace_valid_o), 64'd0);
      chk("mid_pop", 64'(ch_pop_o), 64'd0);
      chk("mid_cnt", 64'(word_cnt_o), 64'd0);
      expect_w(0, 32'h6000_0001);
      expect_w(1, 32'h7000_0000);
      expect_w(0, 32'h6000_0002);
      tick();
      trace_ready_i = 1'b1;
      reset = 1'b0;
      ticks(8);
      chk("mid_cnt_after", 64'(word_cnt_o), 64'd3);
      chk("mid_left", 64'(exp_q.size()), 64'd0);

      // Counter saturation: 20 words, narrow counter stops at 15
      do_reset();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 4; c++) begin
            push(c, 32'h5000_0000 | (r << 8) | c);
            expect_w(c, 32'h5000_0000 | (r << 8) | c);
         end
      enable_i = 1'b1;
      trace_ready_i = 1'b1;
      ticks(26);
      chk("sat_cnt16", 64'(word_cnt_o), 64'd20);
      chk("sat_cnt4", 64'(cnt4), 64'd15);
      chk("sat_left", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_spy_drain_arbiter.md
Name: axi_spy_drain_arbiter

Overview:
Drains the four AXI spy FIFOs (R, AR, AW, W) onto one valid/ready trace stream, so a debug port can read captured traffic. Non-empty FIFOs are served round-robin, one word per grant, and each output word is tagged with its source channel. The block also provides a flush mode, which discards all spy contents without emitting them, and keeps a saturating count of emitted words.

Parameters:
DATA_WIDTH, 32, width of each spy FIFO word and of the trace data
CNT_WIDTH, 16, width of the emitted-word counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable_i  input  1  level; allows draining
flush_i  input  1  single-cycle pulse; request discard of all spy contents
ch_empty_i  input  4  spy FIFO empty flags; bit0=R, bit1=AR, bit2=AW, bit3=W
ch_data_i  input  4*DATA_WIDTH  spy FIFO head words; channel n at [n*DATA_WIDTH +: DATA_WIDTH]
ch_pop_o  output  4  one-hot pop strobes to the spy FIFOs
trace_valid_o  output  1  trace word available
trace_ready_i  input  1  consumer accepts the trace word
trace_data_o  output  DATA_WIDTH  registered trace word
trace_chan_o  output  2  source channel of trace_data_o
busy_o  output  1  high in RUN with the slot full, or in FLUSH
flush_done_o  output  1  one-cycle pulse when a flush completes
word_cnt_o  output  CNT_WIDTH  saturating count of accepted trace words

Behaviour:
- Spy FIFO contract: the head word is valid on ch_data_i while the matching ch_empty_i bit is low. A pop strobe sampled at posedge advances that FIFO, and its empty flag and head reflect the pop in the next cycle.
- Reset (asynchronous assert, synchronous release): state=IDLE; rr_ptr=0; slot empty; trace_valid_o=0; trace_data_o=0; trace_chan_o=0; ch_pop_o=0; busy_o=0; flush_done_o=0; word_cnt_o=0. A reset mid-transfer drops the held word without popping again.
- States:
  - IDLE: no pops. flush_pending → FLUSH. Otherwise enable_i → RUN.
  - RUN: the slot may load when it is empty or is being accepted this cycle (trace_valid_o & trace_ready_i).
    - Load condition: slot may load, no flush_pending, and any channel non-empty.
    - On load: grant = first non-empty channel searching from rr_ptr upward, modulo 4. ch_pop_o[grant]=1 combinationally in that cycle. The slot captures ch_data_i[grant] and grant at the edge. rr_ptr ← grant+1 (mod 4).
    - Sustained rate is one word per cycle while the consumer is ready.
    - enable_i low: stop loading; once the slot is empty → IDLE.
    - flush_pending: stop loading; once the slot is empty → FLUSH.
- flush_pending is set by flush_i in any state and cleared on entry to FLUSH. A flush_i that arrives while in FLUSH is absorbed.
- FLUSH:
  - Each cycle, pop the round-robin-selected non-empty channel (one-hot, same rr_ptr rule); nothing is emitted.
  - When all four empty flags are high in FLUSH: pulse flush_done_o for one cycle and go to IDLE.
  - A flush entered with all FIFOs already empty completes in 1 cycle.
- Output hold rules: trace_valid_o is never deasserted and trace_data_o/trace_chan_o never change while trace_valid_o=1 and trace_ready_i=0.
- Pop rules: ch_pop_o is at most one-hot and never asserted for a channel whose empty bit is high.
- word_cnt_o increments on each trace handshake and saturates at all-ones. It is cleared only by reset.
- busy_o = (state==FLUSH) | (state==RUN & trace_valid_o).

Test Plan:
- Basic order: reset, enable=1, ready=1; R holds A0, A1 and W holds D0 → trace emits (A0,ch0), (D0,ch3), (A1,ch0) on consecutive cycles; word_cnt_o=3.
- Fairness: all four FIFOs hold 2 words, ready=1 → channel order 0,1,2,3,0,1,2,3; exactly one pop per cycle; 8 words emitted.
- Backpressure: ready held 0 for 5 cycles with a word loaded → trace_data_o/trace_chan_o stable, no further pops; ready=1 → transfer resumes with no loss or duplication.
- Flush with a word stalled: slot full, ready=0, flush_i pulse → no pops while the slot is held. Release ready → word accepted, then FLUSH pops all remaining words, flush_done_o pulses once, state returns to IDLE, no extra trace words.
- Reset mid-operation: assert reset asynchronously while trace_valid_o=1 → trace_valid_o and ch_pop_o go 0 immediately and word_cnt_o=0. After release, draining restarts from channel 0.
- Counter saturation: CNT_WIDTH=4 with 20 words accepted → word_cnt_o stops at 15.
